// File: rtl/core_pkg.sv
// Shared encodings for the 16-bit core: opcodes, control-bit positions and
// fixed register/condition values used by decode and later stages.
package core_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CTRL_HALT     = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_JAL      = 5;
  localparam int CTRL_JR       = 6;
  localparam int CTRL_BRANCH   = 7;

  localparam logic [2:0] UNCOND_J = 3'b111;
  localparam logic [3:0] R0       = 4'd0;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 16,
  parameter int REG_W = 4
);
  // A transfer occurs on a rising edge where valid and ready are both high;
  // a raised valid keeps its payload stable until that edge, ready may depend on valid.
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [PC_W-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [3:0]       out_opcode;
  logic [REG_W-1:0] out_rd;
  logic [REG_W-1:0] out_rs;
  logic [REG_W-1:0] out_rt;
  logic [IMM_W-1:0] out_imm;
  logic [2:0]       out_cond;
  logic [7:0]       out_ctrl;
  logic [1:0]       out_re;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm, out_cond, out_ctrl, out_re
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm, out_cond, out_ctrl, out_re
  );
endinterface

// File: rtl/decode_logic.sv
// Pure combinational instruction decoder: instruction word -> register
// indices, immediate, condition, control bits and register read enables.
module decode_logic
  import core_pkg::*;
#(
  parameter int IMM_W    = 16,
  parameter int REG_W    = 4,
  parameter int LINK_REG = 15
) (
  input  logic [15:0]      instr_i,
  output logic [REG_W-1:0] rd_o,
  output logic [REG_W-1:0] rs_o,
  output logic [REG_W-1:0] rt_o,
  output logic [IMM_W-1:0] imm_o,
  output logic [2:0]       cond_o,
  output logic [7:0]       ctrl_o,
  output logic [1:0]       re_o
);

  logic [3:0] op;
  assign op = instr_i[15:12];

  always_comb begin
    rd_o   = '0;
    rs_o   = '0;
    rt_o   = '0;
    imm_o  = '0;
    cond_o = instr_i[11:9];
    ctrl_o = '0;
    re_o   = 2'b00;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        rd_o = REG_W'(instr_i[11:8]);
        rs_o = REG_W'(instr_i[7:4]);
        rt_o = REG_W'(instr_i[3:0]);
        re_o = 2'b11;
        ctrl_o[CTRL_REGWRITE] = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        rd_o  = REG_W'(instr_i[11:8]);
        rs_o  = REG_W'(instr_i[7:4]);
        re_o  = 2'b01;
        imm_o = IMM_W'(instr_i[3:0]);
        ctrl_o[CTRL_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        rd_o  = REG_W'(instr_i[11:8]);
        rs_o  = REG_W'(instr_i[7:4]);
        re_o  = 2'b01;
        imm_o = IMM_W'($signed(instr_i[3:0]));
        ctrl_o[CTRL_REGWRITE] = 1'b1;
        ctrl_o[CTRL_MEMTOREG] = 1'b1;
        ctrl_o[CTRL_MEMREAD]  = 1'b1;
      end
      OP_SW: begin
        rs_o  = REG_W'(instr_i[7:4]);
        rt_o  = REG_W'(instr_i[11:8]);
        re_o  = 2'b11;
        imm_o = IMM_W'($signed(instr_i[3:0]));
        ctrl_o[CTRL_MEMWRITE] = 1'b1;
      end
      OP_LHB: begin
        // LHB merges into the existing upper byte, so rd is also read as rs.
        rd_o  = REG_W'(instr_i[11:8]);
        rs_o  = REG_W'(instr_i[11:8]);
        re_o  = 2'b01;
        imm_o = IMM_W'(instr_i[7:0]);
        ctrl_o[CTRL_REGWRITE] = 1'b1;
      end
      OP_LLB: begin
        rd_o  = REG_W'(instr_i[11:8]);
        imm_o = IMM_W'($signed(instr_i[7:0]));
        ctrl_o[CTRL_REGWRITE] = 1'b1;
      end
      OP_B: begin
        imm_o = IMM_W'($signed(instr_i[8:0]));
        ctrl_o[CTRL_BRANCH] = 1'b1;
      end
      OP_JAL: begin
        rd_o   = REG_W'(LINK_REG);
        imm_o  = IMM_W'($signed(instr_i[11:0]));
        cond_o = UNCOND_J;
        ctrl_o[CTRL_REGWRITE] = 1'b1;
        ctrl_o[CTRL_JAL]      = 1'b1;
        ctrl_o[CTRL_BRANCH]   = 1'b1;
      end
      OP_JR: begin
        rs_o   = REG_W'(instr_i[7:4]);
        re_o   = 2'b01;
        cond_o = UNCOND_J;
        ctrl_o[CTRL_JR]     = 1'b1;
        ctrl_o[CTRL_BRANCH] = 1'b1;
      end
      OP_HLT: begin
        ctrl_o[CTRL_HALT] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: ID/EX output register with valid/ready on both sides,
// load-use interlock, branch flush and sticky halt.
module decode_stage
  import core_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int IMM_W    = 16,
  parameter int REG_W    = 4,
  parameter int LINK_REG = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_stage_if.slave    bus,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             halted
);

  localparam int PW = PC_W + 4 + 3*REG_W + IMM_W + 3 + 8 + 2;

  logic [REG_W-1:0] dec_rd, dec_rs, dec_rt;
  logic [IMM_W-1:0] dec_imm;
  logic [2:0]       dec_cond;
  logic [7:0]       dec_ctrl;
  logic [1:0]       dec_re;

  decode_logic #(
    .IMM_W   (IMM_W),
    .REG_W   (REG_W),
    .LINK_REG(LINK_REG)
  ) u_decode_logic (
    .instr_i(bus.in_instr),
    .rd_o   (dec_rd),
    .rs_o   (dec_rs),
    .rt_o   (dec_rt),
    .imm_o  (dec_imm),
    .cond_o (dec_cond),
    .ctrl_o (dec_ctrl),
    .re_o   (dec_re)
  );

  logic          out_valid_q, out_valid_d;
  logic          halt_pend_q, halt_pend_d;
  logic          halted_q, halted_d;
  logic [PW-1:0] pay_q, pay_d, dec_pay;

  logic [PC_W-1:0]  out_pc;
  logic [3:0]       out_opcode;
  logic [REG_W-1:0] out_rd, out_rs, out_rt;
  logic [IMM_W-1:0] out_imm;
  logic [2:0]       out_cond;
  logic [7:0]       out_ctrl;
  logic [1:0]       out_re;

  assign dec_pay = {bus.in_pc, bus.in_instr[15:12], dec_rd, dec_rs, dec_rt,
                    dec_imm, dec_cond, dec_ctrl, dec_re};
  assign {out_pc, out_opcode, out_rd, out_rs, out_rt,
          out_imm, out_cond, out_ctrl, out_re} = pay_q;

  // A load is in flight if it sits in our own output register or in EX.
  logic ld_id, ld_ex, rs_hit, rt_hit, hazard, accept, in_ready;
  assign ld_id  = out_valid_q && out_ctrl[CTRL_MEMREAD];
  assign ld_ex  = ex_valid && ex_mem_read;
  assign rs_hit = dec_re[0] && (dec_rs != '0) &&
                  ((ld_id && dec_rs == out_rd) || (ld_ex && dec_rs == ex_rd));
  assign rt_hit = dec_re[1] && (dec_rt != '0) &&
                  ((ld_id && dec_rt == out_rd) || (ld_ex && dec_rt == ex_rd));
  assign hazard = rs_hit || rt_hit;

  assign in_ready = rst_n && !halt_pend_q && !halted_q && !flush && !hazard &&
                    (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    halt_pend_d = halt_pend_q;
    halted_d    = halted_q;
    pay_d       = pay_q;
    if (flush) begin
      // The instruction held here is younger than the taken branch, so a
      // HLT leaving in the same cycle is squashed too.
      out_valid_d = 1'b0;
      halt_pend_d = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready && out_ctrl[CTRL_HALT]) halted_d = 1'b1;
      if (accept) begin
        out_valid_d = 1'b1;
        pay_d       = dec_pay;
        if (dec_ctrl[CTRL_HALT]) halt_pend_d = 1'b1;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      pay_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
      pay_q       <= pay_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = out_pc;
  assign bus.out_opcode = out_opcode;
  assign bus.out_rd     = out_rd;
  assign bus.out_rs     = out_rs;
  assign bus.out_rt     = out_rt;
  assign bus.out_imm    = out_imm;
  assign bus.out_cond   = out_cond;
  assign bus.out_ctrl   = out_ctrl;
  assign bus.out_re     = out_re;
  assign halted         = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against an instruction-level reference model with an expected queue.
module tb_decode_stage;

  localparam int W = 61;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic [2:0]  cond;
    logic [7:0]  ctrl;
    logic [1:0]  re;
  } dec_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       ex_valid;
  logic       ex_mem_read;
  logic [3:0] ex_rd;
  logic       halted;

  decode_stage_if #(.PC_W(16), .IMM_W(16), .REG_W(4)) bus ();

  decode_stage #(.PC_W(16), .IMM_W(16), .REG_W(4), .LINK_REG(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .halted     (halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic         m_hp;
  logic         m_halted;
  logic         last_ready;
  logic [W-1:0] dut_word;

  assign dut_word = {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rt,
                     bus.out_imm, bus.out_cond, bus.out_ctrl, bus.out_re};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set table.
  function automatic dec_t ref_decode(input logic [15:0] ins, input logic [15:0] pc);
    dec_t d;
    logic [3:0] op, a, b, c;
    op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
    d = '0;
    d.pc = pc; d.op = op; d.cond = ins[11:9];
    if (op <= 4'd4) begin
      d.rd = a; d.rs = b; d.rt = c; d.re = 2'b11; d.ctrl = 8'h02;
    end else if (op <= 4'd7) begin
      d.rd = a; d.rs = b; d.re = 2'b01; d.imm = {12'h000, c}; d.ctrl = 8'h02;
    end else begin
      case (op)
        4'h8: begin d.rd = a; d.rs = b; d.re = 2'b01; d.imm = {{12{c[3]}}, c}; d.ctrl = 8'h16; end
        4'h9: begin d.rs = b; d.rt = a; d.re = 2'b11; d.imm = {{12{c[3]}}, c}; d.ctrl = 8'h08; end
        4'hA: begin d.rd = a; d.rs = a; d.re = 2'b01; d.imm = {8'h00, ins[7:0]}; d.ctrl = 8'h02; end
        4'hB: begin d.rd = a; d.imm = {{8{ins[7]}}, ins[7:0]}; d.ctrl = 8'h02; end
        4'hC: begin d.imm = {{7{ins[8]}}, ins[8:0]}; d.ctrl = 8'h80; end
        4'hD: begin d.rd = 4'd15; d.imm = {{4{ins[11]}}, ins[11:0]}; d.cond = 3'b111; d.ctrl = 8'hA2; end
        4'hE: begin d.rs = b; d.re = 2'b01; d.cond = 3'b111; d.ctrl = 8'hC0; end
        default: d.ctrl = 8'h01;
      endcase
    end
    return d;
  endfunction

  function automatic logic hit(input logic en, input logic [3:0] r, input logic hv, input dec_t h);
    return en && (r != 4'd0) &&
           ((hv && h.ctrl[4] && r == h.rd) || (ex_valid && ex_mem_read && r == ex_rd));
  endfunction

  function automatic logic model_ready();
    dec_t di, h;
    logic hv;
    di = ref_decode(bus.in_instr, bus.in_pc);
    hv = (exp_q.size() != 0);
    h  = hv ? exp_q[0] : '0;
    return rst_n && !m_hp && !m_halted && !flush && (!hv || bus.out_ready) &&
           !hit(di.re[0], di.rs, hv, h) && !hit(di.re[1], di.rt, hv, h);
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    check("halted", 64'(halted), 64'(m_halted));
    if (exp_q.size() != 0) check("out_word", 64'(dut_word), 64'(exp_q[0]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 64'(dut_word), 64'(0));
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_ready"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_halted"}, 64'(halted), 64'(0));
  endtask

  // driver: one clock cycle with the given inputs, model stepped on the edge
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic fl, input logic exv,
                       input logic exm, input logic [3:0] exr);
    logic er;
    dec_t h, n;
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy;
    flush = fl; ex_valid = exv; ex_mem_read = exm; ex_rd = exr;
    #1;
    er = model_ready();
    last_ready = bus.in_ready;
    check("in_ready", 64'(bus.in_ready), 64'(er));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_hp = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ordy) begin
        h = exp_q.pop_front();
        if (h.ctrl[0]) m_halted = 1'b1;
      end
      if (v && er) begin
        n = ref_decode(ins, pc);
        exp_q.push_back(n);
        if (n.ctrl[0]) m_hp = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0000, 16'h0000, ordy, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc, input logic ordy);
    cycle(1'b1, ins, pc, ordy, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 4'd0;
    #2;
    check_zero(tag);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    m_hp = 1'b0;
    m_halted = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r[15:12] = 4'($urandom_range(0, 14));
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    flush = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 4'd0;
    m_hp = 1'b0; m_halted = 1'b0; last_ready = 1'b0;
    do_reset("reset");

    // ADD: one-cycle latency, fields from the nibbles
    issue(16'h0123, 16'h0100, 1'b1);
    check("add_rd", 64'(bus.out_rd), 64'(1));
    check("add_rs", 64'(bus.out_rs), 64'(2));
    check("add_rt", 64'(bus.out_rt), 64'(3));
    check("add_ctrl", 64'(bus.out_ctrl), 64'(8'h02));
    check("add_re", 64'(bus.out_re), 64'(2'b11));
    idle(1'b1);

    // load-use: ADD r3,r1,r4 waits one cycle behind LW r1
    issue(16'h8120, 16'h0102, 1'b1);
    issue(16'h0314, 16'h0104, 1'b1);
    check("lw_use_stall", 64'(last_ready), 64'(0));
    check("lw_use_bubble", 64'(bus.out_valid), 64'(0));
    issue(16'h0314, 16'h0104, 1'b1);
    check("lw_use_issue", 64'(last_ready), 64'(1));
    check("lw_use_rd", 64'(bus.out_rd), 64'(3));

    // branch immediates and link register
    issue(16'hC1FF, 16'h0106, 1'b1);
    check("b_imm", 64'(bus.out_imm), 64'(16'hFFFF));
    check("b_cond", 64'(bus.out_cond), 64'(0));
    check("b_ctrl", 64'(bus.out_ctrl), 64'(8'h80));
    issue(16'hD800, 16'h0108, 1'b1);
    check("jal_rd", 64'(bus.out_rd), 64'(15));
    check("jal_imm", 64'(bus.out_imm), 64'(16'hF800));
    check("jal_cond", 64'(bus.out_cond), 64'(3'b111));

    // back-pressure: SUB held three cycles, next instruction waits
    issue(16'h1234, 16'h010A, 1'b1);
    repeat (3) begin
      issue(16'h2567, 16'h010C, 1'b0);
      check("stall_ready", 64'(last_ready), 64'(0));
    end
    issue(16'h2567, 16'h010C, 1'b1);
    check("stall_resume", 64'(bus.out_opcode), 64'(2));
    idle(1'b1);

    // HLT flushed before EX takes it
    issue(16'hF000, 16'h0110, 1'b0);
    issue(16'h0123, 16'h0112, 1'b0);
    check("halt_pend_block", 64'(last_ready), 64'(0));
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    issue(16'h0123, 16'h0112, 1'b0);
    check("flush_ready", 64'(last_ready), 64'(1));
    check("flush_halted", 64'(halted), 64'(0));
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 16'($urandom),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
    end

    // reset while an instruction is held under back-pressure
    idle(1'b1);
    idle(1'b1);
    issue(16'h1234, 16'h0200, 1'b0);
    idle(1'b0);
    do_reset("reset_stall");

    // HLT taken by EX: halted sticks, nothing else accepted
    issue(16'hF000, 16'h0300, 1'b1);
    idle(1'b1);
    check("halted_set", 64'(halted), 64'(1));
    repeat (3) begin
      issue(16'h0123, 16'h0302, 1'b1);
      check("halted_block", 64'(last_ready), 64'(0));
    end
    do_reset("reset_final");
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
